// File: rtl/colour_blob_tracker_pkg.sv
// rtl/colour_blob_tracker_pkg.sv - shared types, register map and saturating helpers for the blob tracker
package blob_tracker_pkg;

    localparam int MAX_CH = 8;

    localparam logic [5:0] REG_CTRL      = 6'd0;
    localparam logic [5:0] REG_FRAME_CNT = 6'd1;
    localparam logic [5:0] REG_STATUS    = 6'd2;

    localparam logic [2:0] OFF_THR_MIN = 3'd0;
    localparam logic [2:0] OFF_THR_MAX = 3'd1;
    localparam logic [2:0] OFF_MASS    = 3'd2;
    localparam logic [2:0] OFF_SUM_X   = 3'd3;
    localparam logic [2:0] OFF_SUM_Y   = 3'd4;
    localparam logic [2:0] OFF_BB_MIN  = 3'd5;
    localparam logic [2:0] OFF_BB_MAX  = 3'd6;
    localparam logic [2:0] OFF_VALID   = 3'd7;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_MASK = 2'd1,
        MODE_BBOX = 2'd2,
        MODE_ANY  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [10:0] y;
        logic [10:0] x;
    } coord_t;

    typedef struct packed {
        logic [31:0] mass;
        logic [31:0] sum_x;
        logic [31:0] sum_y;
        coord_t      bb_min;
        coord_t      bb_max;
        logic        valid;
    } chan_stats_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] coord_word(input coord_t c);
        return {5'd0, c.y, 5'd0, c.x};
    endfunction

endpackage

// File: rtl/colour_blob_tracker_if.sv
// rtl/colour_blob_tracker_if.sv - MM slave and video stream bundle for the blob tracker
interface colour_blob_tracker_if;
    logic        s_chipselect;
    logic        s_read;
    logic        s_write;
    logic [5:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    logic [23:0] sink_data;
    logic        sink_valid;
    logic        sink_sop;
    logic        sink_eop;
    logic        sink_ready;

    logic [23:0] source_data;
    logic        source_valid;
    logic        source_sop;
    logic        source_eop;
    logic        source_ready;

    modport slave (
        input  s_chipselect, s_read, s_write, s_address, s_writedata,
        output s_readdata,
        input  sink_data, sink_valid, sink_sop, sink_eop,
        output sink_ready,
        output source_data, source_valid, source_sop, source_eop,
        input  source_ready
    );

    modport master (
        output s_chipselect, s_read, s_write, s_address, s_writedata,
        input  s_readdata,
        output sink_data, sink_valid, sink_sop, sink_eop,
        input  sink_ready,
        input  source_data, source_valid, source_sop, source_eop,
        output source_ready
    );
endinterface

// File: rtl/colour_blob_tracker_stats.sv
// rtl/colour_blob_tracker_stats.sv - one colour channel: box classifier, per-frame accumulators, eop latch
module blob_channel_stats
    import blob_tracker_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  rgb_t        i_pix,
    input  rgb_t        i_thr_min,
    input  rgb_t        i_thr_max,
    input  logic        i_clear,
    input  logic        i_count,
    input  logic        i_latch,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    output logic        o_hit,
    output chan_stats_t o_stats
);
    // The empty bbox is chosen so the first hit always replaces both corners.
    localparam coord_t EMPTY_MIN = '{y: 11'(IMAGE_H - 1), x: 11'(IMAGE_W - 1)};
    localparam chan_stats_t EMPTY_STATS = '{mass: 32'd0, sum_x: 32'd0, sum_y: 32'd0,
                                            bb_min: EMPTY_MIN, bb_max: '0, valid: 1'b0};

    chan_stats_t r_acc;
    chan_stats_t r_stats;
    chan_stats_t w_next;
    logic        w_take;

    assign o_hit = (i_pix.r >= i_thr_min.r) && (i_pix.r <= i_thr_max.r) &&
                   (i_pix.g >= i_thr_min.g) && (i_pix.g <= i_thr_max.g) &&
                   (i_pix.b >= i_thr_min.b) && (i_pix.b <= i_thr_max.b);
    assign w_take  = i_count & o_hit;
    assign o_stats = r_stats;

    // The eop pixel itself must be included, so the latch takes the next-state value.
    always_comb begin
        w_next = r_acc;
        if (w_take) begin
            w_next.mass  = sat_add(r_acc.mass, 32'd1);
            w_next.sum_x = sat_add(r_acc.sum_x, {21'd0, i_x});
            w_next.sum_y = sat_add(r_acc.sum_y, {21'd0, i_y});
            if (i_x < r_acc.bb_min.x) w_next.bb_min.x = i_x;
            if (i_y < r_acc.bb_min.y) w_next.bb_min.y = i_y;
            if (i_x > r_acc.bb_max.x) w_next.bb_max.x = i_x;
            if (i_y > r_acc.bb_max.y) w_next.bb_max.y = i_y;
            w_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= EMPTY_STATS;
            r_stats <= EMPTY_STATS;
        end else begin
            r_acc <= i_clear ? EMPTY_STATS : w_next;
            if (i_latch) r_stats <= w_next;
        end
    end

endmodule

// File: rtl/colour_blob_tracker.sv
// rtl/colour_blob_tracker.sv - multi-channel colour blob tracker with MM register file and video overlay
module colour_blob_tracker
    import blob_tracker_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int NUM_CH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    colour_blob_tracker_if.slave bus
);
    localparam logic [11:0] Y_END = 12'(IMAGE_H);
    localparam logic [10:0] X_LAST = 11'(IMAGE_W - 1);

    rgb_t        r_thr_min_wr [MAX_CH];
    rgb_t        r_thr_max_wr [MAX_CH];
    rgb_t        r_thr_min    [MAX_CH];
    rgb_t        r_thr_max    [MAX_CH];
    logic [4:0]  r_ctrl_wr;
    logic [4:0]  r_ctrl;
    logic [31:0] r_frame_cnt;
    logic        r_frame_done;
    logic [31:0] r_readdata;
    logic        r_in_video;
    logic [10:0] r_x;
    logic [11:0] r_y;
    logic        r_src_valid;
    logic        r_src_sop;
    logic        r_src_eop;
    logic [23:0] r_src_data;

    logic [MAX_CH-1:0] w_hit;
    chan_stats_t       w_stats [MAX_CH];
    chan_stats_t       w_sel_stats;
    mode_e             w_mode;
    logic [2:0]        w_sel;
    logic [2:0]        w_rd_ch;
    logic              w_ch_ok;
    logic              w_ready, w_accept, w_sop_acc, w_pix_acc, w_count, w_latch;
    logic              w_wr, w_rd, w_on_bbox;
    rgb_t              w_pix;
    logic [23:0]       w_out_data;
    logic [31:0]       w_rd_data;
    logic              w_unused;

    assign w_mode    = mode_e'(r_ctrl[1:0]);
    assign w_sel     = r_ctrl[4:2];
    assign w_ready   = ~r_src_valid | bus.source_ready;
    assign w_accept  = bus.sink_valid & w_ready;
    assign w_sop_acc = w_accept & bus.sink_sop;
    assign w_pix_acc = w_accept & ~bus.sink_sop & r_in_video;
    assign w_count   = w_pix_acc & (r_y < Y_END);
    assign w_latch   = w_pix_acc & bus.sink_eop;
    assign w_pix     = rgb_t'(bus.sink_data);
    assign w_wr      = bus.s_chipselect & bus.s_write;
    assign w_rd      = bus.s_chipselect & bus.s_read;
    assign w_rd_ch   = bus.s_address[5:3] - 3'd1;
    assign w_ch_ok   = (bus.s_address[5:3] != 3'd0) && (int'(w_rd_ch) < NUM_CH);
    assign w_unused  = ^bus.s_writedata[31:24];

    assign bus.sink_ready   = w_ready;
    assign bus.source_valid = r_src_valid;
    assign bus.source_sop   = r_src_sop;
    assign bus.source_eop   = r_src_eop;
    assign bus.source_data  = r_src_data;
    assign bus.s_readdata   = r_readdata;

    for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            blob_channel_stats #(.IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H)) u_stats (
                .clk       (clk),
                .rst       (reset),
                .i_pix     (w_pix),
                .i_thr_min (r_thr_min[c]),
                .i_thr_max (r_thr_max[c]),
                .i_clear   (w_sop_acc),
                .i_count   (w_count),
                .i_latch   (w_latch),
                .i_x       (r_x),
                .i_y       (r_y[10:0]),
                .o_hit     (w_hit[c]),
                .o_stats   (w_stats[c])
            );
        end else begin : g_off
            assign w_hit[c]   = 1'b0;
            assign w_stats[c] = '0;
        end
    end

    // Overlay uses the previous frame's latched box; only the outline is painted.
    assign w_sel_stats = w_stats[w_sel];
    assign w_on_bbox = w_sel_stats.valid &&
                       (r_x >= w_sel_stats.bb_min.x) && (r_x <= w_sel_stats.bb_max.x) &&
                       (r_y[10:0] >= w_sel_stats.bb_min.y) && (r_y[10:0] <= w_sel_stats.bb_max.y) &&
                       ((r_x == w_sel_stats.bb_min.x) || (r_x == w_sel_stats.bb_max.x) ||
                        (r_y[10:0] == w_sel_stats.bb_min.y) || (r_y[10:0] == w_sel_stats.bb_max.y));

    always_comb begin
        w_out_data = bus.sink_data;
        if (w_count) begin
            case (w_mode)
                MODE_MASK: w_out_data = w_hit[w_sel] ? 24'hFF_FFFF : 24'h00_0000;
                MODE_BBOX: if (w_on_bbox) w_out_data = 24'hFF_0000;
                MODE_ANY:  w_out_data = (|w_hit) ? 24'hFF_FFFF : 24'h00_0000;
                default:   w_out_data = bus.sink_data;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.s_address)
            REG_CTRL:      w_rd_data = {27'd0, r_ctrl_wr};
            REG_FRAME_CNT: w_rd_data = r_frame_cnt;
            REG_STATUS:    w_rd_data = {31'd0, r_frame_done};
            default: begin
                if (w_ch_ok) begin
                    case (bus.s_address[2:0])
                        OFF_THR_MIN: w_rd_data = {8'd0, r_thr_min_wr[w_rd_ch]};
                        OFF_THR_MAX: w_rd_data = {8'd0, r_thr_max_wr[w_rd_ch]};
                        OFF_MASS:    w_rd_data = w_stats[w_rd_ch].mass;
                        OFF_SUM_X:   w_rd_data = w_stats[w_rd_ch].sum_x;
                        OFF_SUM_Y:   w_rd_data = w_stats[w_rd_ch].sum_y;
                        OFF_BB_MIN:  w_rd_data = coord_word(w_stats[w_rd_ch].bb_min);
                        OFF_BB_MAX:  w_rd_data = coord_word(w_stats[w_rd_ch].bb_max);
                        default:     w_rd_data = {31'd0, w_stats[w_rd_ch].valid};
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < MAX_CH; c++) begin
                r_thr_min_wr[c] <= '1;
                r_thr_max_wr[c] <= '0;
                r_thr_min[c]    <= '1;
                r_thr_max[c]    <= '0;
            end
            r_ctrl_wr    <= '0;
            r_ctrl       <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_readdata   <= '0;
        end else begin
            if (w_wr) begin
                if (bus.s_address == REG_CTRL) r_ctrl_wr <= bus.s_writedata[4:0];
                if (w_ch_ok && bus.s_address[2:0] == OFF_THR_MIN)
                    r_thr_min_wr[w_rd_ch] <= rgb_t'(bus.s_writedata[23:0]);
                if (w_ch_ok && bus.s_address[2:0] == OFF_THR_MAX)
                    r_thr_max_wr[w_rd_ch] <= rgb_t'(bus.s_writedata[23:0]);
            end
            if (w_sop_acc) begin
                r_ctrl    <= r_ctrl_wr;
                r_thr_min <= r_thr_min_wr;
                r_thr_max <= r_thr_max_wr;
            end
            if (w_latch) r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_latch) r_frame_done <= 1'b1;
            else if (w_rd && bus.s_address == REG_STATUS) r_frame_done <= 1'b0;
            if (w_rd) r_readdata <= w_rd_data;
        end
    end

    // Coordinates stop advancing once the frame height is exceeded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_video <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
        end else if (w_sop_acc) begin
            r_in_video <= (bus.sink_data[3:0] == 4'd0);
            r_x        <= '0;
            r_y        <= '0;
        end else if (w_pix_acc) begin
            if (bus.sink_eop) r_in_video <= 1'b0;
            if (r_y < Y_END) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 12'd1;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_src_data  <= '0;
        end else if (w_accept) begin
            r_src_valid <= 1'b1;
            r_src_sop   <= bus.sink_sop;
            r_src_eop   <= bus.sink_eop;
            r_src_data  <= w_out_data;
        end else if (bus.source_ready) begin
            r_src_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_colour_blob_tracker.sv
// tb/tb_colour_blob_tracker.sv - directed self-checking bench for colour_blob_tracker on a 4x2 frame
module tb_colour_blob_tracker;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    colour_blob_tracker_if bus ();

    colour_blob_tracker #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CH(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic        stall_en = 1'b0;
    logic [25:0] outq [$];
    logic [23:0] px [10];
    logic [23:0] ex [10];
    logic [31:0] rd;

    always @(negedge clk)
        if (!reset && bus.source_valid && bus.source_ready)
            outq.push_back({bus.source_sop, bus.source_eop, bus.source_data});

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mm_wr(input logic [5:0] a, input logic [31:0] d);
        bus.s_chipselect = 1'b1; bus.s_write = 1'b1; bus.s_address = a; bus.s_writedata = d;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0; bus.s_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [5:0] a, input string tag, input logic [31:0] exp);
        bus.s_chipselect = 1'b1; bus.s_read = 1'b1; bus.s_address = a;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0; bus.s_read = 1'b0;
        rd = bus.s_readdata;
        chk(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        bus.source_ready = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [23:0] d, input logic sop, input logic eop);
        logic rdy;
        int   guard;
        rdy = 1'b0;
        guard = 0;
        bus.sink_valid = 1'b1; bus.sink_data = d; bus.sink_sop = sop; bus.sink_eop = eop;
        while (!rdy && guard < 100) begin
            if (stall_en) bus.source_ready = 1'($urandom_range(0, 1));
            #1 rdy = bus.sink_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
        if (!rdy) begin
            n_vec++; n_err++;
            $error("FAIL send_timeout observed=stalled expected=accepted");
        end
    endtask

    task automatic send_frame(input logic [23:0] hdr, input logic [23:0] p [10], input int n);
        send(hdr, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) send(p[i], 1'b0, (i == n - 1));
    endtask

    task automatic chk_out(input string tag, input logic [23:0] hdr, input logic [23:0] e [10], input int n);
        int          m;
        logic [25:0] want;
        chk({tag, "_beats"}, 32'(outq.size()), 32'(n + 1));
        m = (outq.size() < n + 1) ? outq.size() : n + 1;
        for (int i = 0; i < m; i++) begin
            if (i == 0) want = {2'b10, hdr};
            else        want = {1'b0, (i == n), e[i-1]};
            chk($sformatf("%s_beat%0d", tag, i), 32'(outq[i]), 32'(want));
        end
        outq.delete();
    endtask

    initial begin
        bus.s_chipselect = 0; bus.s_read = 0; bus.s_write = 0; bus.s_address = '0; bus.s_writedata = '0;
        bus.sink_valid = 0; bus.sink_data = '0; bus.sink_sop = 0; bus.sink_eop = 0; bus.source_ready = 1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_source_valid", 32'(bus.source_valid), 32'd0);
        chk("rst_readdata", bus.s_readdata, 32'd0);
        reset = 1'b0;

        rd_chk(6'd0,  "rst_ctrl", 32'd0);
        rd_chk(6'd1,  "rst_frame_cnt", 32'd0);
        rd_chk(6'd2,  "rst_status", 32'd0);
        rd_chk(6'd8,  "rst_thr_min0", 32'h00FF_FFFF);
        rd_chk(6'd9,  "rst_thr_max0", 32'd0);
        rd_chk(6'd10, "rst_mass0", 32'd0);
        rd_chk(6'd13, "rst_bb_min0", 32'h0001_0003);
        rd_chk(6'd5,  "unmapped_rd", 32'd0);
        rd_chk(6'd14, "rst_bb_max0", 32'd0);
        rd_chk(6'd15, "rst_valid0", 32'd0);

        // ch0 red box, ch1 blue box
        mm_wr(6'd8,  32'h0080_0000);
        mm_wr(6'd9,  32'h00FF_FFFF);
        mm_wr(6'd16, 32'h0000_0080);
        mm_wr(6'd17, 32'h0000_00FF);

        px = '{24'h000000, 24'hFF0000, 24'h101010, 24'h202020,
               24'h000000, 24'h000000, 24'h000000, 24'h900000, 24'h0, 24'h0};
        send_frame(24'h000000, px, 8);
        idle(3);
        chk_out("f1_pass", 24'h000000, px, 8);
        rd_chk(6'd10, "f1_mass0", 32'd2);
        rd_chk(6'd11, "f1_sum_x0", 32'd4);
        rd_chk(6'd12, "f1_sum_y0", 32'd1);
        rd_chk(6'd13, "f1_bb_min0", 32'h0000_0001);
        rd_chk(6'd14, "f1_bb_max0", 32'h0001_0003);
        rd_chk(6'd15, "f1_valid0", 32'd1);
        rd_chk(6'd18, "f1_mass1", 32'd0);
        rd_chk(6'd21, "f1_bb_min1", 32'h0001_0003);
        rd_chk(6'd22, "f1_bb_max1", 32'd0);
        rd_chk(6'd23, "f1_valid1", 32'd0);
        rd_chk(6'd1,  "f1_frame_cnt", 32'd1);
        rd_chk(6'd2,  "f1_status_set", 32'd1);
        rd_chk(6'd2,  "f1_status_clr", 32'd0);

        mm_wr(6'd0, 32'd1);
        ex = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000,
               24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h0, 24'h0};
        send_frame(24'h000000, px, 8);
        idle(3);
        chk_out("f2_mask", 24'h000000, ex, 8);

        stall_en = 1'b1;
        send_frame(24'h000000, px, 8);
        stall_en = 1'b0;
        idle(6);
        chk_out("f3_mask_stall", 24'h000000, ex, 8);
        rd_chk(6'd1, "f3_frame_cnt", 32'd3);

        mm_wr(6'd0, 32'd2);
        px = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
               24'h000005, 24'h000006, 24'h000007, 24'h000008, 24'h0, 24'h0};
        ex = '{24'h000001, 24'hFF0000, 24'hFF0000, 24'hFF0000,
               24'h000005, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h0, 24'h0};
        send_frame(24'h000000, px, 8);
        idle(3);
        chk_out("f4_bbox", 24'h000000, ex, 8);
        rd_chk(6'd15, "f4_valid0", 32'd0);
        rd_chk(6'd13, "f4_bb_min0", 32'h0001_0003);

        mm_wr(6'd0, 32'd3);
        send(24'h000000, 1'b1, 1'b0);
        repeat (4) send(24'h0000FF, 1'b0, 1'b0);
        mm_wr(6'd16, 32'h00FF_FFFF);
        repeat (3) send(24'h0000FF, 1'b0, 1'b0);
        send(24'h0000FF, 1'b0, 1'b1);
        idle(3);
        ex = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
               24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
        chk_out("f5_any", 24'h000000, ex, 8);
        rd_chk(6'd18, "f5_mass1", 32'd8);
        rd_chk(6'd19, "f5_sum_x1", 32'd12);
        rd_chk(6'd20, "f5_sum_y1", 32'd4);
        rd_chk(6'd21, "f5_bb_min1", 32'h0000_0000);
        rd_chk(6'd22, "f5_bb_max1", 32'h0001_0003);
        rd_chk(6'd23, "f5_valid1", 32'd1);

        px = '{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF,
               24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0, 24'h0};
        ex = '{default: 24'h000000};
        send_frame(24'h000000, px, 8);
        idle(3);
        chk_out("f6_any_newthr", 24'h000000, ex, 8);
        rd_chk(6'd18, "f6_mass1", 32'd0);
        rd_chk(6'd23, "f6_valid1", 32'd0);
        rd_chk(6'd1,  "f6_frame_cnt", 32'd6);
        rd_chk(6'd2,  "f6_status_set", 32'd1);

        px = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        send_frame(24'h00000F, px, 3);
        idle(3);
        chk_out("nv_pass", 24'h00000F, px, 3);
        rd_chk(6'd1,  "nv_frame_cnt", 32'd6);
        rd_chk(6'd2,  "nv_status", 32'd0);
        rd_chk(6'd10, "nv_mass0", 32'd0);

        mm_wr(6'd0, 32'd0);
        px = '{24'h000000, 24'h000000, 24'h000000, 24'h000000,
               24'h000000, 24'h000000, 24'hFF0000, 24'h000000, 24'hFF0000, 24'hFF0000};
        send_frame(24'h000000, px, 10);
        idle(3);
        chk_out("f7_overrun", 24'h000000, px, 10);
        rd_chk(6'd10, "f7_mass0", 32'd1);
        rd_chk(6'd11, "f7_sum_x0", 32'd2);
        rd_chk(6'd12, "f7_sum_y0", 32'd1);
        rd_chk(6'd13, "f7_bb_min0", 32'h0001_0002);
        rd_chk(6'd14, "f7_bb_max0", 32'h0001_0002);
        rd_chk(6'd1,  "f7_frame_cnt", 32'd7);

        send(24'h000000, 1'b1, 1'b0);
        send(24'hFF0000, 1'b0, 1'b0);
        send(24'hFF0000, 1'b0, 1'b0);
        chk("pre_rst_source_valid", 32'(bus.source_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_source_valid", 32'(bus.source_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        outq.delete();
        rd_chk(6'd10, "mr_mass0", 32'd0);
        rd_chk(6'd11, "mr_sum_x0", 32'd0);
        rd_chk(6'd13, "mr_bb_min0", 32'h0001_0003);
        rd_chk(6'd15, "mr_valid0", 32'd0);
        rd_chk(6'd8,  "mr_thr_min0", 32'h00FF_FFFF);
        rd_chk(6'd1,  "mr_frame_cnt", 32'd0);
        repeat (7) send(24'hFF0000, 1'b0, 1'b0);
        send(24'hFF0000, 1'b0, 1'b1);
        idle(3);
        rd_chk(6'd1, "nosop_frame_cnt", 32'd0);
        rd_chk(6'd2, "nosop_status", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
